// File: rtl/cr_had_inj_pkg.sv
// Shared HAD injection types: FSM states, FIFO entry layout, FIFO depth.
package cr_had_inj_pkg;

    localparam int INJ_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        INJ_IDLE  = 2'd0,
        INJ_ISSUE = 2'd1,
        INJ_EXEC  = 2'd2
    } inj_state_e;

    // ffy lands on bit 32, instruction word on bits 31:0
    typedef struct packed {
        logic        ffy;
        logic [31:0] ir;
    } inj_entry_t;

    function automatic inj_entry_t inj_pack(input logic ffy, input logic [31:0] ir);
        inj_entry_t e;
        e.ffy = ffy;
        e.ir  = ir;
        return e;
    endfunction

endpackage

// File: rtl/cr_had_inj_fifo.sv
// Two-entry FIFO holding pending injected instructions.
module cr_had_inj_fifo
    import cr_had_inj_pkg::*;
(
    input  logic       cpuclk,
    input  logic       hadrst_b,
    input  logic       push,
    input  logic       pop,
    input  inj_entry_t wdata,
    output inj_entry_t head,
    output logic       full,
    output logic       empty,
    output logic       empty_nxt,
    output logic       drop
);

    inj_entry_t mem [INJ_FIFO_DEPTH];
    logic       wptr;
    logic       rptr;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       wr_en;
    logic       rd_en;

    assign full  = (cnt == 2'(INJ_FIFO_DEPTH));
    assign empty = (cnt == 2'd0);
    assign rd_en = pop && !empty;
    // a pop frees the slot the write lands in, so full+pop still accepts
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && !wr_en;
    assign head  = mem[rptr];

    always_comb begin
        cnt_nxt = cnt;
        if (wr_en && !rd_en) begin
            cnt_nxt = cnt + 2'd1;
        end else if (!wr_en && rd_en) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    assign empty_nxt = (cnt_nxt == 2'd0);

    always_ff @(posedge cpuclk) begin
        if (!hadrst_b) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
            for (int i = 0; i < INJ_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (rd_en) begin
                rptr <= ~rptr;
            end
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/cr_had_inj.sv
// HAD debug instruction injection: source mux, FIFO, issue/exec FSM.
// Optional retirement watchdog enabled by defining HAD_INJ_TIMEOUT_EN.
module cr_had_inj
    import cr_had_inj_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic        cpuclk,
    input  logic        hadrst_b,
    input  logic        ddc_regs_update_ir,
    input  logic [31:0] ddc_regs_ir,
    input  logic        ddc_regs_ffy,
    input  logic        regs_xx_ddc_en,
    input  logic        jtag_xx_update_dr,
    input  logic        regs_inj_ir_sel,
    input  logic [31:0] jtag_xx_data,
    input  logic        regs_inj_clr,
    input  logic        iu_had_inst_ack,
    input  logic        iu_had_xx_retire,
    output logic        had_iu_inst_vld,
    output logic [31:0] had_iu_inst,
    output logic        had_iu_ffy,
    output logic        inj_regs_busy,
    output logic        inj_regs_done,
    output logic        inj_regs_ovf,
    output logic        inj_regs_tmo
);

    inj_state_e state;
    inj_state_e state_nxt;
    inj_entry_t push_data;
    inj_entry_t head;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       empty_nxt;
    logic       drop;
    logic       retire_hit;
    logic       tmo_hit;
    logic       done_q;
    logic       busy_q;
    logic       ovf_q;
    logic       tmo_q;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (regs_xx_ddc_en) begin
            push      = ddc_regs_update_ir;
            push_data = inj_pack(ddc_regs_ffy, ddc_regs_ir);
        end else begin
            push      = jtag_xx_update_dr && regs_inj_ir_sel;
            push_data = inj_pack(1'b0, jtag_xx_data);
        end
    end

    assign pop        = (state == INJ_ISSUE) && iu_had_inst_ack;
    assign retire_hit = (state == INJ_EXEC) && iu_had_xx_retire;

    cr_had_inj_fifo u_fifo (
        .cpuclk    (cpuclk),
        .hadrst_b  (hadrst_b),
        .push      (push),
        .pop       (pop),
        .wdata     (push_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .empty_nxt (empty_nxt),
        .drop      (drop)
    );

`ifdef HAD_INJ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt;

    // a retire on the terminal cycle wins over the abort
    assign tmo_hit = (state == INJ_EXEC) && !iu_had_xx_retire
                   && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge cpuclk) begin
        if (!hadrst_b) begin
            tmo_cnt <= '0;
        end else if (pop) begin
            tmo_cnt <= '0;
        end else if (state == INJ_EXEC) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            INJ_IDLE: begin
                if (!empty) state_nxt = INJ_ISSUE;
            end
            INJ_ISSUE: begin
                if (iu_had_inst_ack) state_nxt = INJ_EXEC;
            end
            INJ_EXEC: begin
                if (iu_had_xx_retire || tmo_hit) state_nxt = INJ_IDLE;
            end
            default: state_nxt = INJ_IDLE;
        endcase
    end

    always_ff @(posedge cpuclk) begin
        if (!hadrst_b) begin
            state  <= INJ_IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= retire_hit;
            busy_q <= !empty_nxt || (state_nxt != INJ_IDLE);
            ovf_q  <= drop || (ovf_q && !regs_inj_clr);
            tmo_q  <= tmo_hit || (tmo_q && !regs_inj_clr);
        end
    end

    assign had_iu_inst_vld = (state == INJ_ISSUE);
    assign had_iu_inst     = had_iu_inst_vld ? head.ir : 32'h0;
    assign had_iu_ffy      = had_iu_inst_vld && head.ffy;
    assign inj_regs_busy   = busy_q;
    assign inj_regs_done   = done_q;
    assign inj_regs_ovf    = ovf_q;
    assign inj_regs_tmo    = tmo_q;

endmodule

// File: tb/tb_cr_had_inj.sv
// Self-checking bench for cr_had_inj: queue-based model plus directed literals.
module tb_cr_had_inj;

    localparam int TMO = 16;
`ifdef HAD_INJ_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        cpuclk = 1'b0;
    logic        hadrst_b = 1'b0;
    logic        ddc_regs_update_ir = 1'b0;
    logic [31:0] ddc_regs_ir = 32'h0;
    logic        ddc_regs_ffy = 1'b0;
    logic        regs_xx_ddc_en = 1'b1;
    logic        jtag_xx_update_dr = 1'b0;
    logic        regs_inj_ir_sel = 1'b0;
    logic [31:0] jtag_xx_data = 32'h0;
    logic        regs_inj_clr = 1'b0;
    logic        iu_had_inst_ack = 1'b0;
    logic        iu_had_xx_retire = 1'b0;
    logic        had_iu_inst_vld;
    logic [31:0] had_iu_inst;
    logic        had_iu_ffy;
    logic        inj_regs_busy;
    logic        inj_regs_done;
    logic        inj_regs_ovf;
    logic        inj_regs_tmo;

    always #5 cpuclk = ~cpuclk;

    cr_had_inj #(.TIMEOUT_CYCLES(TMO)) u_dut (
        .cpuclk             (cpuclk),
        .hadrst_b           (hadrst_b),
        .ddc_regs_update_ir (ddc_regs_update_ir),
        .ddc_regs_ir        (ddc_regs_ir),
        .ddc_regs_ffy       (ddc_regs_ffy),
        .regs_xx_ddc_en     (regs_xx_ddc_en),
        .jtag_xx_update_dr  (jtag_xx_update_dr),
        .regs_inj_ir_sel    (regs_inj_ir_sel),
        .jtag_xx_data       (jtag_xx_data),
        .regs_inj_clr       (regs_inj_clr),
        .iu_had_inst_ack    (iu_had_inst_ack),
        .iu_had_xx_retire   (iu_had_xx_retire),
        .had_iu_inst_vld    (had_iu_inst_vld),
        .had_iu_inst        (had_iu_inst),
        .had_iu_ffy         (had_iu_ffy),
        .inj_regs_busy      (inj_regs_busy),
        .inj_regs_done      (inj_regs_done),
        .inj_regs_ovf       (inj_regs_ovf),
        .inj_regs_tmo       (inj_regs_tmo)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: pending queue, a presenting flag, an executing flag with age.
    logic [32:0] mq[$];
    bit m_pres = 0, m_exec = 0, m_done = 0, m_busy = 0, m_ovf = 0, m_tmo = 0;
    int m_age = 0;

    task automatic model_step();
        bit req, popped, drp, tmo_ev;
        logic [32:0] d;
        if (!hadrst_b) begin
            mq.delete();
            m_pres = 0; m_exec = 0; m_done = 0;
            m_busy = 0; m_ovf = 0; m_tmo = 0; m_age = 0;
            return;
        end
        req = regs_xx_ddc_en ? ddc_regs_update_ir
                             : (jtag_xx_update_dr && regs_inj_ir_sel);
        d = regs_xx_ddc_en ? {ddc_regs_ffy, ddc_regs_ir} : {1'b0, jtag_xx_data};
        popped = m_pres && iu_had_inst_ack;
        tmo_ev = TMO_ON && m_exec && !iu_had_xx_retire && (m_age == TMO - 1);
        m_done = m_exec && iu_had_xx_retire;
        drp = req && (mq.size() == 2) && !popped;
        if (popped) begin
            m_pres = 0; m_exec = 1; m_age = 0;
        end else if (m_exec) begin
            if (m_done || tmo_ev) m_exec = 0;
            else m_age++;
        end else if (!m_pres && mq.size() != 0) begin
            m_pres = 1;
        end
        if (popped) void'(mq.pop_front());
        if (req && !drp) mq.push_back(d);
        m_ovf = drp || (m_ovf && !regs_inj_clr);
        m_tmo = tmo_ev || (m_tmo && !regs_inj_clr);
        m_busy = (mq.size() != 0) || m_pres || m_exec;
    endtask

    initial forever begin
        @(posedge cpuclk);
        model_step();
    end

    initial forever begin
        logic [32:0] hd;
        @(negedge cpuclk);
        if (chk_en) begin
            hd = m_pres ? mq[0] : 33'h0;
            check("cmp_vld",  had_iu_inst_vld, m_pres);
            check("cmp_inst", had_iu_inst, hd[31:0]);
            check("cmp_ffy",  had_iu_ffy, hd[32]);
            check("cmp_busy", inj_regs_busy, m_busy);
            check("cmp_done", inj_regs_done, m_done);
            check("cmp_ovf",  inj_regs_ovf, m_ovf);
            check("cmp_tmo",  inj_regs_tmo, m_tmo);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    task automatic tick();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic push_ddc(input logic [31:0] ir, input logic ffy);
        ddc_regs_update_ir = 1'b1;
        ddc_regs_ir        = ir;
        ddc_regs_ffy       = ffy;
        tick();
        ddc_regs_update_ir = 1'b0;
    endtask

    task automatic pulse_ack();
        iu_had_inst_ack = 1'b1;
        tick();
        iu_had_inst_ack = 1'b0;
    endtask

    task automatic pulse_retire();
        iu_had_xx_retire = 1'b1;
        tick();
        iu_had_xx_retire = 1'b0;
    endtask

    task automatic wait_vld(input int maxc);
        for (int i = 0; i < maxc && !had_iu_inst_vld; i++) tick();
        check("wait_vld", had_iu_inst_vld, 1'b1);
    endtask

    initial begin
        repeat (2) tick();
        chk_en = 1'b1;
        check("lit_rst_vld",  had_iu_inst_vld, 1'b0);
        check("lit_rst_inst", had_iu_inst, 32'h0);
        check("lit_rst_busy", inj_regs_busy, 1'b0);
        check("lit_rst_ovf",  inj_regs_ovf, 1'b0);
        hadrst_b = 1'b1;
        tick();

        // single DDC push: cycle 0 push, vld at 2, ack 3, retire 5, done 6
        push_ddc(32'h00008093, 1'b1);
        check("lit_busy_c1", inj_regs_busy, 1'b1);
        check("lit_vld_c1", had_iu_inst_vld, 1'b0);
        tick();
        check("lit_vld_c2", had_iu_inst_vld, 1'b1);
        check("lit_inst_c2", had_iu_inst, 32'h00008093);
        check("lit_ffy_c2", had_iu_ffy, 1'b1);
        tick();
        pulse_ack();
        tick();
        pulse_retire();
        check("lit_done_c6", inj_regs_done, 1'b1);
        tick();
        check("lit_done_c7", inj_regs_done, 1'b0);
        check("lit_busy_c7", inj_regs_busy, 1'b0);

        // stray ack while idle is ignored
        pulse_ack();
        tick();

        // JTAG push with a concurrent DDC strobe that must be ignored
        regs_xx_ddc_en     = 1'b0;
        jtag_xx_update_dr  = 1'b1;
        regs_inj_ir_sel    = 1'b1;
        jtag_xx_data       = 32'h0020a023;
        ddc_regs_update_ir = 1'b1;
        ddc_regs_ir        = 32'hdeadbeef;
        ddc_regs_ffy       = 1'b1;
        tick();
        jtag_xx_update_dr  = 1'b0;
        ddc_regs_update_ir = 1'b0;
        tick();
        check("lit_jtag_inst", had_iu_inst, 32'h0020a023);
        check("lit_jtag_ffy", had_iu_ffy, 1'b0);
        pulse_ack();
        jtag_xx_update_dr = 1'b1;
        regs_inj_ir_sel   = 1'b0;
        jtag_xx_data      = 32'hffffffff;
        pulse_retire();
        jtag_xx_update_dr = 1'b0;
        check("lit_jtag_done", inj_regs_done, 1'b1);
        repeat (2) tick();
        check("lit_jtag_idle", inj_regs_busy, 1'b0);
        regs_xx_ddc_en = 1'b1;

        // overflow: third consecutive push dropped
        push_ddc(32'h00008093, 1'b0);
        push_ddc(32'h00010113, 1'b0);
        push_ddc(32'h00018193, 1'b0);
        check("lit_ovf_set", inj_regs_ovf, 1'b1);
        check("lit_ovf_head", had_iu_inst, 32'h00008093);
        regs_inj_clr = 1'b1;
        tick();
        regs_inj_clr = 1'b0;
        check("lit_ovf_clr", inj_regs_ovf, 1'b0);
        pulse_ack();
        pulse_retire();
        wait_vld(8);
        check("lit_ovf_second", had_iu_inst, 32'h00010113);
        pulse_ack();
        pulse_retire();
        repeat (3) tick();
        check("lit_ovf_drained", inj_regs_busy, 1'b0);

        // push and pop in the same cycle while full
        push_ddc(32'h00100093, 1'b0);
        push_ddc(32'h00200113, 1'b1);
        check("lit_pp_head", had_iu_inst, 32'h00100093);
        iu_had_inst_ack    = 1'b1;
        ddc_regs_update_ir = 1'b1;
        ddc_regs_ir        = 32'h00300193;
        ddc_regs_ffy       = 1'b0;
        tick();
        iu_had_inst_ack    = 1'b0;
        ddc_regs_update_ir = 1'b0;
        check("lit_pp_no_ovf", inj_regs_ovf, 1'b0);
        pulse_retire();
        wait_vld(8);
        check("lit_pp_b", had_iu_inst, 32'h00200113);
        check("lit_pp_b_ffy", had_iu_ffy, 1'b1);
        pulse_ack();
        pulse_retire();
        wait_vld(8);
        check("lit_pp_c", had_iu_inst, 32'h00300193);
        pulse_ack();
        pulse_retire();
        tick();

        // watchdog: 16 EXEC cycles without retire
        push_ddc(32'h00400213, 1'b0);
        wait_vld(8);
        pulse_ack();
        repeat (TMO) tick();
        check("lit_tmo_flag", inj_regs_tmo, TMO_ON);
        check("lit_tmo_busy", inj_regs_busy, !TMO_ON);
        check("lit_tmo_nodone", inj_regs_done, 1'b0);
        if (!TMO_ON) pulse_retire();
        regs_inj_clr = 1'b1;
        tick();
        regs_inj_clr = 1'b0;
        check("lit_tmo_clr", inj_regs_tmo, 1'b0);

        // retire on the terminal watchdog cycle wins
        push_ddc(32'h00500293, 1'b0);
        wait_vld(8);
        pulse_ack();
        repeat (TMO - 1) tick();
        pulse_retire();
        check("lit_tmo_edge_done", inj_regs_done, 1'b1);
        check("lit_tmo_edge_tmo", inj_regs_tmo, 1'b0);
        tick();

        // reset mid-EXEC with a pending entry and ovf set
        push_ddc(32'h00600313, 1'b0);
        push_ddc(32'h00700393, 1'b0);
        push_ddc(32'h00800413, 1'b0);
        pulse_ack();
        hadrst_b = 1'b0;
        tick();
        hadrst_b = 1'b1;
        check("lit_mr_vld", had_iu_inst_vld, 1'b0);
        check("lit_mr_busy", inj_regs_busy, 1'b0);
        check("lit_mr_ovf", inj_regs_ovf, 1'b0);
        pulse_retire();
        check("lit_mr_nodone", inj_regs_done, 1'b0);
        repeat (3) tick();
        check("lit_mr_empty", had_iu_inst_vld, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cr_had_inj.md
# cr_had_inj

Debug instruction-injection stage for the HAD unit. Accepts instruction-register (IR) loads from the DDC sequencer or from direct JTAG IR writes. Buffers them in a 2-entry FIFO and presents each one to the IU with a valid/ack handshake. It then tracks the instruction to retirement and reports completion back to HAD regs. It sits between the DDC/regs logic and the IU debug-fetch path.

## Interface
- `TIMEOUT_CYCLES`, default 1024. Watchdog limit in cycles. Used only with `HAD_INJ_TIMEOUT_EN`.
- `cpuclk`  in  1  core clock; all state updates on its rising edge.
- `hadrst_b`  in  1  reset; synchronous, active-low.
- `ddc_regs_update_ir`  in  1  DDC IR load strobe.
- `ddc_regs_ir`  in  32  DDC instruction word.
- `ddc_regs_ffy`  in  1  DDC ffy flag, stored with the instruction.
- `regs_xx_ddc_en`  in  1  DDC mode enable.
- `jtag_xx_update_dr`  in  1  JTAG update-DR strobe.
- `regs_inj_ir_sel`  in  1  JTAG DR targets IR.
- `jtag_xx_data`  in  32  JTAG shifted data.
- `regs_inj_clr`  in  1  clears the sticky status bits.
- `iu_had_inst_ack`  in  1  IU accepted the presented instruction.
- `iu_had_xx_retire`  in  1  injected instruction retired.
- `had_iu_inst_vld`  out  1  instruction presented.
- `had_iu_inst`  out  32  presented instruction.
- `had_iu_ffy`  out  1  ffy flag of the presented instruction.
- `inj_regs_busy`  out  1  FIFO non-empty or FSM not IDLE.
- `inj_regs_done`  out  1  one-cycle pulse per retirement.
- `inj_regs_ovf`  out  1  sticky: a push was dropped.
- `inj_regs_tmo`  out  1  sticky: watchdog abort (0 when the watchdog is compiled out).

## Operation
- **Push source**
  - When `regs_xx_ddc_en`=1, the push source is `ddc_regs_update_ir`, carrying `{ddc_regs_ffy, ddc_regs_ir}`.
  - When `regs_xx_ddc_en`=0, the push source is `jtag_xx_update_dr && regs_inj_ir_sel`, carrying `{1'b0, jtag_xx_data}`.
  - The non-selected source is ignored.
- **FIFO**
  - 2 entries of 33 bits each, 1-bit read/write pointers, 2-bit count.
  - A push while full (and no pop in the same cycle) is dropped and sets `inj_regs_ovf`.
  - Push and pop in the same cycle are both honoured at any count, including full. Count is unchanged.
- **FSM**, encoded 2 bits:
  - IDLE(0): if the FIFO is non-empty, go to ISSUE.
  - ISSUE(1): `had_iu_inst_vld`=1 and `had_iu_inst`/`had_iu_ffy` show the FIFO head. `iu_had_inst_ack`=1 pops the head and moves to EXEC. The head must stay stable until ack.
  - EXEC(2): wait for `iu_had_xx_retire`. On retire, `inj_regs_done` pulses the next cycle and the FSM goes to IDLE.
  - Encoding 3 is illegal and goes to IDLE.
- `iu_had_xx_retire` outside EXEC is ignored. `iu_had_inst_ack` outside ISSUE is ignored.
- `regs_inj_clr` clears `inj_regs_ovf` and `inj_regs_tmo`. If a set event occurs in the same cycle as the clear, the set wins.

## Timing
- Reset values:
  - FSM=IDLE, FIFO empty.
  - `had_iu_inst_vld`=0, `had_iu_inst`=0, `had_iu_ffy`=0.
  - `inj_regs_busy`=0, `inj_regs_done`=0, `inj_regs_ovf`=0, `inj_regs_tmo`=0.
- Reset asserted mid-operation discards all entries and the in-flight instruction. No done pulse is generated.
- Latency:
  - A push at cycle N gives `had_iu_inst_vld`=1 at N+2 when the block is idle (N+1 FIFO write, IDLE→ISSUE).
  - Retire at cycle M gives `inj_regs_done`=1 at M+1.
  - The next ISSUE occurs no earlier than M+2.
- `had_iu_inst`/`had_iu_ffy` are 0 whenever `had_iu_inst_vld`=0.
- `inj_regs_busy` is a registered output (derived from next-state) and is valid the cycle after the push.

## Configuration
- **With `HAD_INJ_TIMEOUT_EN` defined:**
  - A counter (width `$clog2(TIMEOUT_CYCLES)+1`) clears on entry to EXEC and increments each EXEC cycle.
  - When it reaches `TIMEOUT_CYCLES-1` without a retire, the FSM goes to IDLE, `inj_regs_tmo` sets, and no done pulse is generated.
  - A retire in the same cycle as the timeout takes priority: done pulses and tmo stays clear.
- **Without it:** no counter is built, EXEC waits indefinitely, and `inj_regs_tmo` is tied to 0.

## Structure
- Shared HAD package holds:
  - the FSM state constants `INJ_IDLE`, `INJ_ISSUE`, `INJ_EXEC`;
  - the 33-bit entry layout, with ffy at bit 32;
  - `INJ_FIFO_DEPTH`=2.
- One sub-module, `cr_had_inj_fifo`, implements the 2-entry FIFO with push, pop, full, empty and head.
- FSM, source mux, sticky flags and watchdog live in the top module.

## Test plan
- **Single DDC push:** ddc_en=1; push ir=32'h00008093, ffy=1 at cycle 0 → vld=1, inst=32'h00008093, ffy=1 at cycle 2. Ack at cycle 3, retire at cycle 5 → done=1 at cycle 6 only, busy=0 at cycle 7.
- **JTAG push:** ddc_en=0; update_dr+ir_sel with data 32'h0020a023 → presented with ffy=0. Concurrent DDC strobes are ignored.
- **Overflow:** three pushes on consecutive cycles with no ack → third push dropped, ovf=1. Entries issue in order 32'h00008093, then 32'h00010113. regs_inj_clr → ovf=0.
- **Push and pop while full:** FIFO full and ISSUE acked in the same cycle as a push → no ovf, count stays 2, order preserved.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** ack, then no retire → IDLE after 16 EXEC cycles, tmo=1, done never pulses. Retire in cycle 16 → done=1, tmo=0.
- **Reset mid-EXEC:** hadrst_b=0 for one cycle → all outputs at reset values next edge. A later retire produces no done.
